set_less_than_seq: RTL and testbench



---
 rtl/set_less_than_seq.sv | 66 ++++++
 tb/tb_set_less_than_seq.sv | 109 ++++++++++
 2 files changed

// File: rtl/set_less_than_seq.sv
// set_less_than_seq: multi-cycle signed/unsigned set-less-than, one CHUNK-bit slice per cycle from the MSB down.
module set_less_than_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic             lt,
  output logic             eq
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] xr, yr;
  logic sgn, last, diff;
  logic [IW-1:0] idx;
  logic [CHUNK-1:0] xs, ys;
  assign last      = idx == IW'(N - 1);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign Z         = {{(WIDTH-1){1'b0}}, lt};
  // flipping both sign bits of the top slice turns a signed compare into an unsigned one
  always_comb begin
    xs = xr[idx*CHUNK +: CHUNK];
    ys = yr[idx*CHUNK +: CHUNK];
    xs[CHUNK-1] = xs[CHUNK-1] ^ (sgn & last);
    ys[CHUNK-1] = ys[CHUNK-1] ^ (sgn & last);
    diff = xs != ys;
    state_nx = state == IDLE ? (in_valid ? RUN : IDLE)
             : state == RUN  ? ((diff || idx == '0) ? DONE : RUN)
             : (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      lt    <= 1'b0;
      eq    <= 1'b0;
    end else begin
      state <= state_nx;
      if (in_valid && in_ready) begin
        xr  <= X;
        yr  <= Y;
        sgn <= is_signed;
        idx <= IW'(N - 1);
      end
      if (state == RUN) begin
        if (diff) begin
          lt <= xs < ys;
          eq <= 1'b0;
        end else if (idx == '0) begin
          lt <= 1'b0;
          eq <= 1'b1;
        end else idx <= idx - IW'(1);
      end
    end
  end
endmodule

// File: tb/tb_set_less_than_seq.sv
// tb_set_less_than_seq: directed checks of a sliced (CHUNK=8) and a single-slice (CHUNK=32) instance.
module tb_set_less_than_seq;
  logic clk = 0;
  logic rst_n = 0;
  logic [1:0] in_valid = '0, in_ready, is_signed = '0, out_valid, out_ready = '0, lt, eq;
  logic [31:0] xv [2], yv [2], zv [2];
  int total = 0, fails = 0;
  always #5 clk = ~clk;
  set_less_than_seq #(.WIDTH(32), .CHUNK(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .X(xv[0]), .Y(yv[0]),
    .is_signed(is_signed[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .Z(zv[0]), .lt(lt[0]), .eq(eq[0]));
  set_less_than_seq #(.WIDTH(32), .CHUNK(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .X(xv[1]), .Y(yv[1]),
    .is_signed(is_signed[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .Z(zv[1]), .lt(lt[1]), .eq(eq[1]));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // issue one operation and wait for its result; lat counts edges from the accept edge inclusive
  task automatic start(input int d, input logic [31:0] x, input logic [31:0] y, input logic s, output int lat);
    xv[d] = x; yv[d] = y; is_signed[d] = s; in_valid[d] = 1;
    tick();
    in_valid[d] = 0; xv[d] = ~x; yv[d] = ~y; is_signed[d] = ~s;
    lat = 1;
    while (!out_valid[d] && lat < 40) begin
      tick();
      lat++;
    end
  endtask
  task automatic run(input int d, input string tag, input logic [31:0] x, input logic [31:0] y,
                     input logic s, input logic elt, input logic eeq, input int elat);
    int lat;
    start(d, x, y, s, lat);
    chk({tag, " latency"}, lat, elat);
    chk({tag, " lt"}, lt[d], elt);
    chk({tag, " eq"}, eq[d], eeq);
    chk({tag, " Z"}, zv[d], {31'b0, elt});
    out_ready[d] = 1;
    tick();
    out_ready[d] = 0;
    chk({tag, " in_ready after handshake"}, in_ready[d], 1);
    chk({tag, " out_valid after handshake"}, out_valid[d], 0);
  endtask
  initial begin
    int lat;
    xv[0] = 0; yv[0] = 0; xv[1] = 0; yv[1] = 0;
    tick(); tick();
    chk("reset out_valid", out_valid[0], 0);
    chk("reset lt", lt[0], 0);
    chk("reset eq", eq[0], 0);
    chk("reset Z", zv[0], 0);
    chk("reset in_ready", in_ready[0], 1);
    rst_n = 1;
    tick();
    run(0, "signed -1<1", 32'hFFFFFFFF, 32'h00000001, 1, 1, 0, 2);
    run(0, "unsigned max>1", 32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 2);
    run(0, "unsigned lsb slice", 32'h12345678, 32'h12345679, 0, 1, 0, 5);
    run(0, "signed equal min", 32'h80000000, 32'h80000000, 1, 0, 1, 5);
    run(0, "signed max>min", 32'h7FFFFFFF, 32'h80000000, 1, 0, 0, 2);
    run(0, "unsigned max<min", 32'h7FFFFFFF, 32'h80000000, 0, 1, 0, 2);
    run(0, "signed low slice no flip", 32'hFFFFFF80, 32'hFFFFFF01, 1, 0, 0, 5);
    // backpressure: result held while the consumer stalls, new operands refused
    start(0, 32'h00000003, 32'h00000100, 0, lat);
    chk("bp latency", lat, 4);
    xv[0] = 32'h1; yv[0] = 32'h0; in_valid[0] = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp out_valid held", out_valid[0], 1);
      chk("bp lt held", lt[0], 1);
      chk("bp eq held", eq[0], 0);
      chk("bp Z held", zv[0], 32'h1);
      chk("bp in_ready low", in_ready[0], 0);
    end
    in_valid[0] = 0; out_ready[0] = 1;
    tick();
    out_ready[0] = 0;
    chk("bp in_ready after handshake", in_ready[0], 1);
    chk("bp lt retained in idle", lt[0], 1);
    // reset in the middle of an equal-operand compare
    xv[0] = 32'hAAAAAAAA; yv[0] = 32'hAAAAAAAA; is_signed[0] = 0; in_valid[0] = 1;
    tick();
    in_valid[0] = 0;
    tick();
    chk("mid-run out_valid", out_valid[0], 0);
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("abort out_valid", out_valid[0], 0);
    chk("abort lt", lt[0], 0);
    chk("abort eq", eq[0], 0);
    chk("abort Z", zv[0], 0);
    chk("abort in_ready", in_ready[0], 1);
    tick(); tick(); tick(); tick();
    chk("abort result discarded", out_valid[0], 0);
    run(1, "single 5<7", 32'd5, 32'd7, 0, 1, 0, 2);
    run(1, "single signed -1<1", 32'hFFFFFFFF, 32'h1, 1, 1, 0, 2);
    run(1, "single equal", 32'h1234, 32'h1234, 1, 0, 1, 2);
    run(0, "after abort equal", 32'hAAAAAAAA, 32'hAAAAAAAA, 0, 0, 1, 5);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
